// File: rtl/mem_bist_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mem_bist_pkg
// Brief    : Shared types, constants and LFSR step for the on-chip memory BIST.
// Revision : 1.0 - initial release
// ============================================================================
package mem_bist_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WRITE  = 3'd1,
      ST_READ   = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_FINISH = 3'd4
   } state_t;

   localparam logic        c_mode_addr_xor = 1'b0;
   localparam logic        c_mode_lfsr     = 1'b1;
   // x^32 + x^22 + x^2 + x + 1 in right-shifting Galois form
   localparam logic [31:0] c_lfsr_poly     = 32'h8020_0003;
   localparam int          c_err_w         = 16;

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return {1'b0, s[31:1]} ^ (s[0] ? c_lfsr_poly : 32'h0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/onchip_mem_bist_master_if.sv
`default_nettype none
// ============================================================================
// Interface : onchip_mem_bist_master_if
// Brief     : Avalon-MM word-addressed bus between the BIST master and RAM s1.
// Revision  : 1.0 - initial release
// ============================================================================
interface onchip_mem_bist_master_if #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 32
) ();
   logic [ADDR_W-1:0]   avm_address;
   logic [DATA_W/8-1:0] avm_byteenable;
   logic                avm_chipselect;
   logic                avm_write;
   logic [DATA_W-1:0]   avm_writedata;
   logic                avm_read;
   logic [DATA_W-1:0]   avm_readdata;
   logic                avm_waitrequest;

   modport master (
      output avm_address, avm_byteenable, avm_chipselect, avm_write,
             avm_writedata, avm_read,
      input  avm_readdata, avm_waitrequest
   );

   modport slave (
      input  avm_address, avm_byteenable, avm_chipselect, avm_write,
             avm_writedata, avm_read,
      output avm_readdata, avm_waitrequest
   );
endinterface
`default_nettype wire

// File: rtl/mem_bist_patgen.sv
`default_nettype none
// ============================================================================
// Module   : mem_bist_patgen
// Brief    : Registered pattern word for the current index; load selects index 0.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bist_patgen
   import mem_bist_pkg::*;
#(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              mode,
   input  logic [DATA_W-1:0] seed,
   input  logic              load,
   input  logic              advance,
   input  logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] word
);
   logic [31:0]       r_lfsr;
   logic [DATA_W-1:0] r_word;
   logic [31:0]       w_lfsr_src;
   logic [DATA_W-1:0] w_addr_word;

   // addr is the address of the word being produced (base on load, next on advance)
   always_comb begin
      w_lfsr_src  = load ? ((32'(seed) == 32'h0) ? 32'h1 : 32'(seed)) : lfsr_next(r_lfsr);
      w_addr_word = DATA_W'(addr) ^ seed;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_lfsr <= '0;
         r_word <= '0;
      end else if (load || advance) begin
         r_lfsr <= w_lfsr_src;
         r_word <= (mode == c_mode_lfsr) ? DATA_W'(w_lfsr_src) : w_addr_word;
      end
   end

   assign word = r_word;

endmodule
`default_nettype wire

// File: rtl/onchip_mem_bist_master.sv
`default_nettype none
// ============================================================================
// Module   : onchip_mem_bist_master
// Brief    : Avalon-MM BIST master: fill a word range, read back, count mismatches.
// Revision : 1.0 - initial release
// ============================================================================
module onchip_mem_bist_master
   import mem_bist_pkg::*;
#(
   parameter int ADDR_W       = 14,
   parameter int DATA_W       = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic [ADDR_W-1:0]      base_addr,
   input  logic [ADDR_W:0]        word_count,
   input  logic                   mode,
   input  logic [DATA_W-1:0]      seed,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [c_err_w-1:0]     err_count,
   output logic [ADDR_W-1:0]      first_err_addr,
   onchip_mem_bist_master_if.master avm
);
   state_t                  r_state, w_state_nxt;
   logic [ADDR_W-1:0]       r_base, r_addr, r_cmp_addr, r_first_err;
   logic [ADDR_W:0]         r_count, r_issued;
   logic [DATA_W-1:0]       r_seed;
   logic [c_err_w-1:0]      r_err;
   logic [READ_LATENCY-1:0] r_vpipe, w_vpipe_nxt;
   logic                    r_mode, r_write, r_read, r_cs;
   logic                    r_busy, r_done, r_pass, r_err_seen;
   logic                    w_start_ok, w_accept, w_last, w_cmp_valid, w_mismatch, w_mode_eff;
   logic [DATA_W-1:0]       w_seed_eff, w_wr_word, w_cmp_word;
   logic [ADDR_W-1:0]       w_wr_gen_addr, w_cmp_gen_addr;

   always_comb begin
      w_start_ok     = start && (r_state == ST_IDLE);
      w_accept       = (r_write || r_read) && !avm.avm_waitrequest;
      w_last         = (r_issued == r_count - (ADDR_W+1)'(1));
      w_vpipe_nxt    = (r_vpipe << 1) | READ_LATENCY'(r_read && w_accept);
      w_cmp_valid    = r_vpipe[READ_LATENCY-1];
      w_mismatch     = w_cmp_valid && (avm.avm_readdata != w_cmp_word);
      // generators see the live inputs on the load cycle, latched copies afterwards
      w_mode_eff     = (r_state == ST_IDLE) ? mode : r_mode;
      w_seed_eff     = (r_state == ST_IDLE) ? seed : r_seed;
      w_wr_gen_addr  = w_start_ok ? base_addr : r_addr + ADDR_W'(1);
      w_cmp_gen_addr = w_start_ok ? base_addr : r_cmp_addr + ADDR_W'(1);
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (w_start_ok) w_state_nxt = (word_count == '0) ? ST_FINISH : ST_WRITE;
         ST_WRITE:  if (w_accept && w_last) w_state_nxt = ST_READ;
         ST_READ:   if (w_accept && w_last) w_state_nxt = ST_DRAIN;
         ST_DRAIN:  if (w_vpipe_nxt == '0) w_state_nxt = ST_FINISH;
         ST_FINISH: w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_base      <= '0;
         r_count     <= '0;
         r_mode      <= 1'b0;
         r_seed      <= '0;
         r_issued    <= '0;
         r_addr      <= '0;
         r_cmp_addr  <= '0;
         r_write     <= 1'b0;
         r_read      <= 1'b0;
         r_cs        <= 1'b0;
         r_vpipe     <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_err       <= '0;
         r_err_seen  <= 1'b0;
         r_first_err <= '0;
      end else begin
         r_vpipe <= w_vpipe_nxt;
         r_done  <= (r_state == ST_FINISH);
         r_busy  <= (w_state_nxt != ST_IDLE);
         if (w_start_ok) begin
            r_base      <= base_addr;
            r_count     <= word_count;
            r_mode      <= mode;
            r_seed      <= seed;
            r_err       <= '0;
            r_first_err <= '0;
            r_err_seen  <= 1'b0;
            r_pass      <= 1'b0;
            r_issued    <= '0;
            r_addr      <= base_addr;
            r_cmp_addr  <= base_addr;
            r_write     <= (word_count != '0);
            r_cs        <= (word_count != '0);
         end else if (w_accept) begin
            if (!w_last) begin
               r_issued <= r_issued + (ADDR_W+1)'(1);
               r_addr   <= r_addr + ADDR_W'(1);
            end else begin
               // last write hands over to reads; last read drops all strobes
               r_issued <= '0;
               r_addr   <= r_base;
               r_read   <= r_write;
               r_cs     <= r_write;
               r_write  <= 1'b0;
            end
         end
         if (w_cmp_valid) r_cmp_addr <= r_cmp_addr + ADDR_W'(1);
         if (w_mismatch) begin
            if (r_err != {c_err_w{1'b1}}) r_err <= r_err + c_err_w'(1);
            if (!r_err_seen) begin
               r_err_seen  <= 1'b1;
               r_first_err <= r_cmp_addr;
            end
         end
         if (r_state == ST_FINISH) r_pass <= (r_err == '0);
      end
   end

   mem_bist_patgen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr_gen (
      .clk     (clk),
      .reset_n (reset_n),
      .mode    (w_mode_eff),
      .seed    (w_seed_eff),
      .load    (w_start_ok),
      .advance (r_write && w_accept),
      .addr    (w_wr_gen_addr),
      .word    (w_wr_word)
   );

   mem_bist_patgen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_cmp_gen (
      .clk     (clk),
      .reset_n (reset_n),
      .mode    (w_mode_eff),
      .seed    (w_seed_eff),
      .load    (w_start_ok),
      .advance (w_cmp_valid),
      .addr    (w_cmp_gen_addr),
      .word    (w_cmp_word)
   );

   assign busy               = r_busy;
   assign done               = r_done;
   assign pass               = r_pass;
   assign err_count          = r_err;
   assign first_err_addr     = r_first_err;
   assign avm.avm_address    = r_addr;
   assign avm.avm_byteenable = {(DATA_W/8){1'b1}};
   assign avm.avm_chipselect = r_cs;
   assign avm.avm_write      = r_write;
   assign avm.avm_writedata  = w_wr_word;
   assign avm.avm_read       = r_read;

endmodule
`default_nettype wire

// File: tb/tb_onchip_mem_bist_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_onchip_mem_bist_master
// Brief    : Directed self-checking bench with an Avalon RAM model and stall injection.
// Revision : 1.0 - initial release
// ============================================================================
module tb_onchip_mem_bist_master;
   localparam int ADDR_W = 14;
   localparam int DATA_W = 32;
   localparam int RL     = 3;
   localparam int BUDGET = 2000;

   logic              clk = 1'b0;
   logic              reset_n = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [ADDR_W:0]   word_count = '0;
   logic              mode = 1'b0;
   logic [DATA_W-1:0] seed = '0;
   logic              busy, done, pass;
   logic [15:0]       err_count;
   logic [ADDR_W-1:0] first_err_addr;

   onchip_mem_bist_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_avm ();

   onchip_mem_bist_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(RL)) u_dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start          (start),
      .base_addr      (base_addr),
      .word_count     (word_count),
      .mode           (mode),
      .seed           (seed),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .err_count      (err_count),
      .first_err_addr (first_err_addr),
      .avm            (u_avm)
   );

   always #5 clk = ~clk;

   // RAM model with optional stuck-at-1 on bit 3 of word 5
   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
   logic [DATA_W-1:0] rd_pipe [0:RL-1];
   logic [ADDR_W-1:0] wr_log[$];
   logic [ADDR_W-1:0] rd_log[$];
   int n_wr = 0, n_rd = 0, n_unstable = 0, n_stalls = 0;
   bit fault_en = 1'b0, stall_en = 1'b0;

   assign u_avm.avm_readdata = rd_pipe[RL-1];

   always @(posedge clk) begin
      if (u_avm.avm_chipselect && !u_avm.avm_waitrequest) begin
         if (u_avm.avm_write) begin
            mem[u_avm.avm_address] <= (fault_en && u_avm.avm_address == 14'd5) ?
                                      (u_avm.avm_writedata | 32'h8) : u_avm.avm_writedata;
            n_wr <= n_wr + 1;
            wr_log.push_back(u_avm.avm_address);
         end
         if (u_avm.avm_read) begin
            n_rd <= n_rd + 1;
            rd_log.push_back(u_avm.avm_address);
         end
      end
      rd_pipe[0] <= (u_avm.avm_read && u_avm.avm_chipselect && !u_avm.avm_waitrequest) ?
                    mem[u_avm.avm_address] : 32'hDEAD_0BAD;
      for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
   end

   // waitrequest for the current cycle is chosen here, then stability of stalled requests is checked
   logic [ADDR_W-1:0] p_addr;
   logic [DATA_W-1:0] p_data;
   logic              p_wr, p_rd;
   bit                p_stalled = 1'b0;
   int                stall_run = 0;
   always @(negedge clk) begin
      if (stall_en && stall_run < 3 && $urandom_range(0, 1) == 1) begin
         u_avm.avm_waitrequest = 1'b1;
         stall_run++;
      end else begin
         u_avm.avm_waitrequest = 1'b0;
         stall_run = 0;
      end
      if (p_stalled && (u_avm.avm_address != p_addr || u_avm.avm_writedata != p_data ||
                        u_avm.avm_write != p_wr || u_avm.avm_read != p_rd))
         n_unstable++;
      p_stalled = (u_avm.avm_read || u_avm.avm_write) && u_avm.avm_waitrequest;
      if (p_stalled) n_stalls++;
      p_addr = u_avm.avm_address;
      p_data = u_avm.avm_writedata;
      p_wr   = u_avm.avm_write;
      p_rd   = u_avm.avm_read;
   end

   int n_checks = 0, n_fail = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   logic busy_c1;

   // start is sampled at the end of cycle 0; done_cyc is the cycle in which done is seen
   task automatic run_bist(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n,
                           input logic m, input logic [31:0] s, input int stray_at,
                           output int done_cyc);
      @(negedge clk);
      base_addr = b; word_count = n; mode = m; seed = s; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      base_addr = ~b; seed = ~s; word_count = '1; mode = ~m;
      busy_c1 = busy;
      done_cyc = -1;
      for (int c = 1; c < BUDGET; c++) begin
         if (done) begin
            done_cyc = c;
            break;
         end
         start = (c == stray_at);
         @(negedge clk);
      end
      start = 1'b0;
      if (done_cyc < 0) check("done_timeout", 64'd0, 64'd1);
   endtask

   int dc, w0, r0, wi, ri;

   initial begin
      #1 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_status", {busy, done, pass, err_count, first_err_addr}, 64'd0);
      check("rst_bus", {u_avm.avm_write, u_avm.avm_read, u_avm.avm_chipselect,
                        u_avm.avm_address, u_avm.avm_writedata}, 64'd0);
      check("rst_byteenable", u_avm.avm_byteenable, 64'hF);
      reset_n = 1'b1;

      // clean run, mode 0
      w0 = n_wr; r0 = n_rd;
      run_bist(14'd0, 15'd16, 1'b0, 32'hA5A5_0000, 0, dc);
      check("A_busy_c1", busy_c1, 1);
      check("A_done_cycle", dc, 2*16 + RL + 2);
      check("A_pass", pass, 1);
      check("A_err", err_count, 0);
      check("A_busy_at_done", busy, 0);
      check("A_writes", n_wr - w0, 16);
      check("A_reads", n_rd - r0, 16);
      check("A_mem3", mem[3], 32'hA5A5_0003);
      @(negedge clk);
      check("A_done_pulse", done, 0);
      check("A_pass_held", pass, 1);

      // stuck-at fault at word 5, LFSR mode
      fault_en = 1'b1;
      run_bist(14'd0, 15'd8, 1'b1, 32'h1, 0, dc);
      fault_en = 1'b0;
      check("B_done_cycle", dc, 2*8 + RL + 2);
      check("B_err", err_count, 1);
      check("B_first_addr", first_err_addr, 5);
      check("B_pass", pass, 0);
      check("B_mem1_lfsr", mem[1], 32'h8020_0003);

      // empty range
      w0 = n_wr; r0 = n_rd;
      run_bist(14'd0, 15'd0, 1'b0, 32'h0, 0, dc);
      check("E_done_cycle", dc, 2);
      check("E_pass", pass, 1);
      check("E_first_addr", first_err_addr, 0);
      check("E_bus_idle", (n_wr - w0) + (n_rd - r0), 0);

      // wrap past the top of the address space
      wi = wr_log.size(); ri = rd_log.size();
      run_bist(14'h3FFE, 15'd4, 1'b0, 32'h1234_5678, 0, dc);
      check("C_wr_n", wr_log.size() - wi, 4);
      check("C_rd_n", rd_log.size() - ri, 4);
      if (wr_log.size() >= wi + 4)
         check("C_wr_addrs", {wr_log[wi], wr_log[wi+1], wr_log[wi+2], wr_log[wi+3]},
               {14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001});
      if (rd_log.size() >= ri + 4)
         check("C_rd_addrs", {rd_log[ri], rd_log[ri+1], rd_log[ri+2], rd_log[ri+3]},
               {14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001});
      check("C_mem3fff", mem[14'h3FFF], 32'h1234_6987);
      check("C_mem1", mem[1], 32'h1234_5679);
      check("C_pass", pass, 1);

      // random waitrequest, LFSR mode
      w0 = n_wr; r0 = n_rd;
      stall_en = 1'b1;
      run_bist(14'd0, 15'd32, 1'b1, 32'hDEAD_BEEF, 0, dc);
      stall_en = 1'b0;
      check("D_pass", pass, 1);
      check("D_err", err_count, 0);
      check("D_writes", n_wr - w0, 32);
      check("D_reads", n_rd - r0, 32);
      check("D_stalls_seen", n_stalls > 0, 1);
      check("D_stable_while_stalled", n_unstable, 0);
      check("D_mem0", mem[0], 32'hDEAD_BEEF);
      check("D_mem1", mem[1], 32'hEF76_DF74);

      // stray start while writing
      w0 = n_wr;
      run_bist(14'h100, 15'd8, 1'b0, 32'h0F0F_0000, 3, dc);
      check("F_done_cycle", dc, 2*8 + RL + 2);
      check("F_writes", n_wr - w0, 8);
      check("F_last_wr_addr", wr_log[wr_log.size()-1], 14'h107);
      check("F_pass", pass, 1);

      // reset in the middle of the read phase
      @(negedge clk);
      base_addr = 14'd0; word_count = 15'd16; mode = 1'b0; seed = 32'h5555_AAAA; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      check("G_in_read", u_avm.avm_read, 1);
      #2 reset_n = 1'b0;
      #1;
      check("G_strobes_async", {u_avm.avm_write, u_avm.avm_read, u_avm.avm_chipselect}, 0);
      check("G_status_async", {busy, done, pass, err_count, first_err_addr}, 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("G_idle_after", {busy, u_avm.avm_read, u_avm.avm_address}, 0);
      check("G_byteenable", u_avm.avm_byteenable, 64'hF);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
